logic_unit_arbiter: RTL



---
 rtl/logic_unit_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
// Optional grant statistics counters are enabled by defining LOGIC_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no result held, any valid request is accepted
// HOLD  | result held on resp_*, waiting for resp_ready
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             winner;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             transfer;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    // On a tie the requester that did not win last time gets the unit.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign can_accept = (state == IDLE) | resp_ready;
    assign grant0     = can_accept & req0_valid & ~winner;
    assign grant1     = can_accept & req1_valid & winner;
    assign transfer   = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign resp_valid = (state == HOLD);

    assign sel_op = winner ? req1_op : req0_op;
    assign sel_a  = winner ? req1_a  : req0_a;
    assign sel_b  = winner ? req1_b  : req0_b;

    always_comb begin
        result = '0;
        case (sel_op)
            OP_AND:  result = sel_a & sel_b;
            OP_OR:   result = sel_a | sel_b;
            OP_XOR:  result = sel_a ^ sel_b;
            OP_NOR:  result = ~(sel_a | sel_b);
            default: result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    state_nxt = transfer ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response and pointer only move on an actual transfer, so backpressure holds them stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data  <= '0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (transfer) begin
            resp_data  <= result;
            resp_id    <= winner;
            last_grant <= winner;
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (grant0 && (grant0_cnt != {CNT_W{1'b1}})) begin
                grant0_cnt <= grant0_cnt + CNT_W'(1);
            end
            if (grant1 && (grant1_cnt != {CNT_W{1'b1}})) begin
                grant1_cnt <= grant1_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
